// File: rtl/f_ibuf_pkg.sv
// Shared fetch/decode pipeline definitions: constants and the fetch-pair record.
package f_ibuf_pkg;

  localparam logic [31:0] RESET_PC  = 32'h0000_3000;
  localparam logic [31:0] NOP_WORD  = 32'h0000_0000;
  localparam int          DEPTH_DEF = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_pair_t;

endpackage

// File: rtl/f_ibuf_ctrl.sv
// Pointer/occupancy bookkeeping for the fetch buffer, including the
// flush-with-keep survivor selection.
module f_ibuf_ctrl
  import f_ibuf_pkg::*;
#(
  parameter  int DEPTH = DEPTH_DEF,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_in_valid,
  input  logic          i_out_ready,
  input  logic          i_flush,
  input  logic          i_flush_keep,
  output logic          o_in_ready,
  output logic          o_out_valid,
  output logic          o_wr_en,
  output logic [AW-1:0] o_rd_ptr,
  output logic [AW-1:0] o_wr_ptr,
  output logic [CW-1:0] o_count
);

  logic [AW-1:0] r_rd_ptr, r_wr_ptr;
  logic [CW-1:0] r_count;
  logic [AW-1:0] w_rd_nxt, w_wr_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_push, w_pop;

  // Ready is taken from the pre-pop count: no pass-through when full.
  assign o_in_ready  = (r_count != CW'(DEPTH));
  assign o_out_valid = (r_count != '0);
  assign w_push      = i_in_valid & o_in_ready;
  assign w_pop       = o_out_valid & i_out_ready;
  assign o_wr_en     = w_push & ~i_flush;

  assign o_rd_ptr = r_rd_ptr;
  assign o_wr_ptr = r_wr_ptr;
  assign o_count  = r_count;

  always_comb begin
    w_rd_nxt  = r_rd_ptr;
    w_wr_nxt  = r_wr_ptr;
    w_cnt_nxt = r_count;
    if (i_flush) begin
      // Survivor is whatever would be the head after this cycle's pop.
      if (i_flush_keep && w_pop && r_count >= CW'(2)) begin
        w_rd_nxt  = r_rd_ptr + AW'(1);
        w_wr_nxt  = r_rd_ptr + AW'(2);
        w_cnt_nxt = CW'(1);
      end else if (i_flush_keep && !w_pop && r_count >= CW'(1)) begin
        w_wr_nxt  = r_rd_ptr + AW'(1);
        w_cnt_nxt = CW'(1);
      end else begin
        w_rd_nxt  = r_wr_ptr;
        w_cnt_nxt = '0;
      end
    end else begin
      if (w_push) w_wr_nxt = r_wr_ptr + AW'(1);
      if (w_pop)  w_rd_nxt = r_rd_ptr + AW'(1);
      if (w_push && !w_pop)      w_cnt_nxt = r_count + CW'(1);
      else if (!w_push && w_pop) w_cnt_nxt = r_count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_rd_ptr <= w_rd_nxt;
      r_wr_ptr <= w_wr_nxt;
      r_count  <= w_cnt_nxt;
    end
  end

endmodule

// File: rtl/f_ibuf.sv
// Instruction fetch buffer: queues {pc, instr} pairs between fetch and decode,
// with redirect flush that can keep one delay-slot entry.
module f_ibuf
  import f_ibuf_pkg::*;
#(
  parameter  int          DEPTH    = DEPTH_DEF,
  parameter  logic [31:0] RESET_PC = f_ibuf_pkg::RESET_PC,
  localparam int          AW       = $clog2(DEPTH),
  localparam int          CW       = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_pc,
  input  logic [31:0]   in_instr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_pc,
  output logic [31:0]   out_instr,
  input  logic          flush,
  input  logic          flush_keep,
  output logic [CW-1:0] count
);

  generate
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("f_ibuf: DEPTH must be a power of two >= 2");
    end
    if (RESET_PC[1:0] != 2'b00) begin : g_bad_pc
      $error("f_ibuf: RESET_PC must be word aligned");
    end
  endgenerate

  fetch_pair_t   r_mem [DEPTH];
  fetch_pair_t   w_head;
  logic          w_wr_en;
  logic [AW-1:0] w_rd_ptr, w_wr_ptr;

  f_ibuf_ctrl #(.DEPTH(DEPTH)) u_ctrl (
    .clk         (clk),
    .reset       (reset),
    .i_in_valid  (in_valid),
    .i_out_ready (out_ready),
    .i_flush     (flush),
    .i_flush_keep(flush_keep),
    .o_in_ready  (in_ready),
    .o_out_valid (out_valid),
    .o_wr_en     (w_wr_en),
    .o_rd_ptr    (w_rd_ptr),
    .o_wr_ptr    (w_wr_ptr),
    .o_count     (count)
  );

  // Storage is not reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[w_wr_ptr] <= '{pc: in_pc, instr: in_instr};
  end

  assign w_head    = r_mem[w_rd_ptr];
  assign out_pc    = out_valid ? w_head.pc    : NOP_WORD;
  assign out_instr = out_valid ? w_head.instr : NOP_WORD;

endmodule

// File: tb/tb_f_ibuf.sv
// Randomized and directed bench for f_ibuf against a queue-based reference model.
module tb_f_ibuf;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, out_valid, out_ready, flush, flush_keep;
  logic [31:0] in_pc, in_instr, out_pc, out_instr;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  logic [63:0] q[$];  // {pc, instr}, front = head

  always #5 clk = ~clk;

  f_ibuf #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .flush(flush), .flush_keep(flush_keep), .count(count)
  );

  function automatic logic [31:0] ins_of(input logic [31:0] pc);
    return pc ^ 32'hDEAD_0001;
  endfunction

  // One clock: apply inputs, check invariants, advance the model, clock, settle.
  task automatic cyc(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                     input logic ordy, input logic fl, input logic kp, input logic rst);
    logic push, pop;
    int   cnt_before;
    reset = rst; in_valid = v; in_pc = pc; in_instr = ins;
    out_ready = ordy; flush = fl; flush_keep = kp;
    #1;
    checks++;
    if (!rst && count > 3'(DEPTH)) begin
      errors++; $display("FAIL count_bound: count=%0d limit=%0d", count, DEPTH);
    end
    checks++;
    if (!rst && v && in_ready && pc[1:0] != 2'b00) begin
      errors++; $display("FAIL pc_align: pc=%h needs low bits 00", pc);
    end
    push = v && (q.size() != DEPTH);
    pop  = ordy && (q.size() != 0);
    cnt_before = q.size();
    if (rst) q.delete();
    else if (fl) begin
      if (pop) void'(q.pop_front());
      if (kp && q.size() >= 1) begin
        logic [63:0] keep;
        keep = q[0]; q.delete(); q.push_back(keep);
      end else q.delete();
    end else begin
      if (pop)  void'(q.pop_front());
      if (push) q.push_back({pc, ins});
    end
    @(posedge clk); #1;
    // A refused push must not grow occupancy.
    checks++;
    if (!rst && !fl && v && cnt_before == DEPTH && int'(count) > cnt_before - (pop ? 1 : 0)) begin
      errors++; $display("FAIL push_when_full: count=%0d expected %0d", count, cnt_before - (pop ? 1 : 0));
    end
  endtask

  task automatic push1(input logic [31:0] pc, input logic ordy);
    cyc(1'b1, pc, ins_of(pc), ordy, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle(input logic ordy);
    cyc(1'b0, 32'h0, 32'h0, ordy, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset;
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    reset = 1'b0; #1;
    checks += 5;
    if (count !== 3'd0)      begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
    if (out_valid !== 1'b0)  begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    if (in_ready !== 1'b1)   begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    if (out_pc !== 32'h0)    begin errors++; $display("FAIL reset_out_pc: got %h want 0", out_pc); end
    if (out_instr !== 32'h0) begin errors++; $display("FAIL reset_out_instr: got %h want 0", out_instr); end
  endtask

  task automatic test_fill;
    for (int i = 0; i < 4; i++) begin
      push1(32'h3000 + 32'(4 * i), 1'b0);
      checks += 2;
      if (out_pc !== 32'h3000) begin errors++; $display("FAIL fill_head: got %h want 00003000", out_pc); end
      if (count !== 3'(i + 1)) begin errors++; $display("FAIL fill_count: got %0d want %0d", count, i + 1); end
    end
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready: got %b want 0", in_ready); end
    push1(32'h3010, 1'b0);  // held by fetch
    checks += 2;
    if (count !== 3'd4)      begin errors++; $display("FAIL fill_hold_count: got %0d want 4", count); end
    if (out_pc !== 32'h3000) begin errors++; $display("FAIL fill_hold_head: got %h want 00003000", out_pc); end
  endtask

  task automatic test_full_pop;
    push1(32'h3010, 1'b1);  // pop accepted, push refused
    checks += 3;
    if (count !== 3'd3)      begin errors++; $display("FAIL fullpop_count: got %0d want 3", count); end
    if (in_ready !== 1'b1)   begin errors++; $display("FAIL fullpop_in_ready: got %b want 1", in_ready); end
    if (out_pc !== 32'h3004) begin errors++; $display("FAIL fullpop_head: got %h want 00003004", out_pc); end
    for (int i = 0; i < 3; i++) begin
      idle(1'b1);
      checks++;
      if (out_pc !== (q.size() != 0 ? q[0][63:32] : 32'h0)) begin
        errors++; $display("FAIL drain_head: got %h want %h", out_pc, (q.size() != 0 ? q[0][63:32] : 32'h0));
      end
    end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty: out_valid %b want 0", out_valid); end
  endtask

  task automatic test_stream;
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    push1(32'h3000, 1'b1);
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL stream_first_valid: got %b want 1", out_valid); end
    for (int i = 1; i <= 9; i++) begin
      checks++;
      if (out_pc !== 32'h3000 + 32'(4 * (i - 1))) begin
        errors++; $display("FAIL stream_head: got %h want %h", out_pc, 32'h3000 + 32'(4 * (i - 1)));
      end
      push1(32'h3000 + 32'(4 * i), 1'b1);
      checks++;
      if (count !== 3'd1) begin errors++; $display("FAIL stream_count: got %0d want 1", count); end
    end
    checks++;
    if (out_instr !== ins_of(32'h3024)) begin
      errors++; $display("FAIL stream_instr: got %h want %h", out_instr, ins_of(32'h3024));
    end
  endtask

  task automatic test_flush;
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) push1(32'h3000 + 32'(4 * i), 1'b0);
    cyc(1'b1, 32'h3100, ins_of(32'h3100), 1'b0, 1'b1, 1'b0, 1'b0);
    checks += 4;
    if (count !== 3'd0)      begin errors++; $display("FAIL flush_count: got %0d want 0", count); end
    if (out_valid !== 1'b0)  begin errors++; $display("FAIL flush_valid: got %b want 0", out_valid); end
    if (out_instr !== 32'h0) begin errors++; $display("FAIL flush_instr: got %h want 0", out_instr); end
    if (out_pc !== 32'h0)    begin errors++; $display("FAIL flush_pc: got %h want 0", out_pc); end
    push1(32'h3200, 1'b0);
    checks += 2;
    if (count !== 3'd1)      begin errors++; $display("FAIL flush_refill_count: got %0d want 1", count); end
    if (out_pc !== 32'h3200) begin errors++; $display("FAIL flush_refill_head: got %h want 00003200", out_pc); end
  endtask

  task automatic test_flush_keep;
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) push1(32'h3000 + 32'(4 * i), 1'b0);
    cyc(1'b1, 32'h3300, ins_of(32'h3300), 1'b1, 1'b1, 1'b1, 1'b0);
    checks += 2;
    if (count !== 3'd1)      begin errors++; $display("FAIL keep_pop_count: got %0d want 1", count); end
    if (out_pc !== 32'h3004) begin errors++; $display("FAIL keep_pop_head: got %h want 00003004", out_pc); end
    push1(32'h4000, 1'b0);
    idle(1'b1);
    checks++;
    if (out_pc !== 32'h4000) begin errors++; $display("FAIL keep_follow: got %h want 00004000", out_pc); end
    // Keep without pop: head survives.
    push1(32'h5000, 1'b0);
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    checks += 2;
    if (count !== 3'd1)      begin errors++; $display("FAIL keep_nopop_count: got %0d want 1", count); end
    if (out_pc !== 32'h4000) begin errors++; $display("FAIL keep_nopop_head: got %h want 00004000", out_pc); end
    // Keep with pop of the only entry leaves nothing.
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0);
    checks++;
    if (count !== 3'd0) begin errors++; $display("FAIL keep_last_count: got %0d want 0", count); end
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 3; i++) push1(32'h3000 + 32'(4 * i), 1'b0);
    cyc(1'b1, 32'h3400, ins_of(32'h3400), 1'b1, 1'b1, 1'b1, 1'b1);
    checks += 3;
    if (count !== 3'd0)     begin errors++; $display("FAIL rstmid_count: got %0d want 0", count); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b want 0", out_valid); end
    if (in_ready !== 1'b1)  begin errors++; $display("FAIL rstmid_ready: got %b want 1", in_ready); end
    push1(32'h3000, 1'b0);
    checks += 2;
    if (out_valid !== 1'b1)  begin errors++; $display("FAIL rstmid_push_valid: got %b want 1", out_valid); end
    if (out_pc !== 32'h3000) begin errors++; $display("FAIL rstmid_push_head: got %h want 00003000", out_pc); end
  endtask

  task automatic test_random;
    logic [31:0] pc;
    logic [31:0] exp_pc, exp_ins;
    for (int n = 0; n < 600; n++) begin
      pc = $urandom() & 32'hFFFF_FFFC;
      cyc($urandom_range(0, 3) != 0, pc, $urandom(), $urandom_range(0, 2) != 0,
          $urandom_range(0, 11) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 99) == 0);
      exp_pc  = (q.size() != 0) ? q[0][63:32] : 32'h0;
      exp_ins = (q.size() != 0) ? q[0][31:0]  : 32'h0;
      checks += 5;
      if (count !== 3'(q.size()))         begin errors++; $display("FAIL rnd_count: got %0d want %0d", count, q.size()); end
      if (out_valid !== (q.size() != 0))  begin errors++; $display("FAIL rnd_valid: got %b want %b", out_valid, q.size() != 0); end
      if (in_ready !== (q.size() != DEPTH)) begin errors++; $display("FAIL rnd_ready: got %b want %b", in_ready, q.size() != DEPTH); end
      if (out_pc !== exp_pc)              begin errors++; $display("FAIL rnd_pc: got %h want %h", out_pc, exp_pc); end
      if (out_instr !== exp_ins)          begin errors++; $display("FAIL rnd_instr: got %h want %h", out_instr, exp_ins); end
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_pc = '0; in_instr = '0;
    out_ready = 1'b0; flush = 1'b0; flush_keep = 1'b0;
    test_reset;
    test_fill;
    test_full_pop;
    test_stream;
    test_flush;
    test_flush_keep;
    test_reset_mid;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
